// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ core: default widths, FSM state
// encoding and instruction field slicing.
//
// An instruction word is {A, B, C}, each field AW bits wide:
//   A = source operand address, B = destination operand address,
//   C = branch target taken when mem[B]-mem[A] <= 0.

`ifndef SUBLEQ_PKG_SV
`define SUBLEQ_PKG_SV

// Field slices of an instruction word w with address width aw.
`define SUBLEQ_FIELD_A(w, aw) w[3*(aw)-1:2*(aw)]
`define SUBLEQ_FIELD_B(w, aw) w[2*(aw)-1:(aw)]
`define SUBLEQ_FIELD_C(w, aw) w[(aw)-1:0]

package subleq_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_READA  = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

endpackage

`endif

// File: rtl/subleq_alu.sv
// Combinational SUBLEQ arithmetic.
//   a   : subtrahend (mem[A])
//   b   : minuend    (mem[B])
//   res : b - a, modulo 2^DW
//   leq : res <= 0 when res is read as two's complement

module subleq_alu #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] res,
  output logic          leq
);

  assign res = b - a;
  assign leq = res[DW-1] | (res == '0);

endmodule

// File: rtl/subleq_core.sv
// SUBLEQ fetch/execute sequencer. Runs one instruction every four cycles
// (FETCH, DECODE, READA, EXEC) against a registered ROM and a synchronous RAM.
//
// Ports:
//   CLK, RST_N  clock and asynchronous active-low reset
//   run         start/continue enable, only looked at while in S_FETCH
//   rom_addr    instruction address (= PC)
//   rom_data    instruction word, valid one cycle after rom_addr
//   ram_addr    data RAM address
//   ram_rdata   RAM read data, valid the cycle after ram_addr
//   ram_wdata   RAM write data (result of the subtraction)
//   ram_we      RAM write strobe, only in S_EXEC
//   pc          current program counter
//   retire      one-cycle pulse when an instruction completes
//   halted      sticky flag, set by a taken branch to HALT_ADDR

module subleq_core
  import subleq_pkg::*;
#(
  parameter int             AW        = AW_DEF,
  parameter int             DW        = DW_DEF,
  parameter logic [AW-1:0]  RESET_PC  = '0,
  parameter logic [AW-1:0]  HALT_ADDR = '1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            run,
  output logic [AW-1:0]   rom_addr,
  input  logic [3*AW-1:0] rom_data,
  output logic [AW-1:0]   ram_addr,
  input  logic [DW-1:0]   ram_rdata,
  output logic [DW-1:0]   ram_wdata,
  output logic            ram_we,
  output logic [AW-1:0]   pc,
  output logic            retire,
  output logic            halted
);

  state_t            state_q,  state_d;
  logic [AW-1:0]     pc_q,     pc_d;
  logic [3*AW-1:0]   ir_q,     ir_d;
  logic [DW-1:0]     opa_q,    opa_d;
  logic              halted_q, halted_d;

  logic [DW-1:0]     alu_res;
  logic              alu_leq;

  // In S_EXEC the RAM is returning mem[B]; opA was captured a cycle earlier.
  subleq_alu #(.DW(DW)) u_alu (
    .a   (opa_q),
    .b   (ram_rdata),
    .res (alu_res),
    .leq (alu_leq)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    opa_d     = opa_q;
    halted_d  = halted_q;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    retire    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (run) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Address A comes straight from the ROM so its read overlaps the IR load.
        ir_d     = rom_data;
        ram_addr = `SUBLEQ_FIELD_A(rom_data, AW);
        state_d  = S_READA;
      end
      S_READA: begin
        opa_d    = ram_rdata;
        ram_addr = `SUBLEQ_FIELD_B(ir_q, AW);
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        ram_addr  = `SUBLEQ_FIELD_B(ir_q, AW);
        ram_wdata = alu_res;
        ram_we    = 1'b1;
        retire    = 1'b1;
        if (alu_leq && (`SUBLEQ_FIELD_C(ir_q, AW) == HALT_ADDR)) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          pc_d    = alu_leq ? `SUBLEQ_FIELD_C(ir_q, AW) : pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        // Terminal: hold the last address, no further writes.
        ram_addr = `SUBLEQ_FIELD_B(ir_q, AW);
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      opa_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      opa_q    <= opa_d;
      halted_q <= halted_d;
    end
  end

  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_subleq_core.sv
// Bench for subleq_core: behavioural registered ROM and synchronous RAM,
// a program-level SUBLEQ model checked every cycle, plus directed tests.

module tb_subleq_core;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_rdata;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  pc;
  logic        retire;
  logic        halted;

  subleq_core dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .run       (run),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .pc        (pc),
    .retire    (retire),
    .halted    (halted)
  );

  always #5 CLK = ~CLK;

  // Registered ROM and synchronous RAM (read returns old data on a write).
  logic [23:0] rom [256];
  logic [7:0]  mem [256];

  always @(posedge CLK) rom_data <= rom[rom_addr];

  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int total = 0;
  int bad = 0;
  int retire_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program-level model: architectural PC, memory image and halt flag.
  logic [7:0] model_mem [256];
  logic [7:0] model_pc = 8'h00;
  bit         model_halted = 1'b0;
  bit         mon_en = 1'b0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      model_pc     = 8'h00;
      model_halted = 1'b0;
    end else if (mon_en) begin
      chk("pc", pc, model_pc);
      chk("rom_addr", rom_addr, model_pc);
      chk("halted", halted, model_halted);
      if (retire) begin
        logic [23:0] ins;
        logic [7:0]  fa, fb, fc, res;
        if (model_halted) chk("retire_in_halt", retire, 1'b0);
        ins = rom[model_pc];
        fa  = ins[23:16];
        fb  = ins[15:8];
        fc  = ins[7:0];
        res = model_mem[fb] - model_mem[fa];
        chk("exec_we", ram_we, 1'b1);
        chk("exec_addr", ram_addr, fb);
        chk("exec_wdata", ram_wdata, res);
        model_mem[fb] = res;
        retire_cnt++;
        if ($signed(res) <= 0 && fc == 8'hFF) model_halted = 1'b1;
        else if ($signed(res) <= 0)           model_pc = fc;
        else                                  model_pc = model_pc + 8'd1;
      end else begin
        chk("idle_we", ram_we, 1'b0);
        chk("idle_wdata", ram_wdata, 8'h00);
      end
    end
  end

  task automatic setup();
    RST_N = 1'b0;
    run   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom[i]       = 24'h0;
      mem[i]       = 8'h0;
      model_mem[i] = 8'h0;
    end
  endtask

  task automatic setm(input logic [7:0] a, input logic [7:0] v);
    mem[a]       = v;
    model_mem[a] = v;
  endtask

  task automatic release_run();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    run   = 1'b1;
  endtask

  task automatic wait_ret(input int n, input int budget);
    int tgt;
    tgt = retire_cnt + n;
    for (int k = 0; k < budget && retire_cnt < tgt; k++) @(posedge CLK);
    #1;
    chk("retire_count", retire_cnt, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    mon_en = 1'b1;

    // 1) reset state, first-retire latency, reset mid-EXEC aborts the write
    setup();
    rom[0] = {8'h10, 8'h11, 8'h05};
    setm(8'h10, 8'd3);
    setm(8'h11, 8'd7);
    #1;
    chk("t1_rst_we", ram_we, 1'b0);
    chk("t1_rst_pc", pc, 8'h00);
    chk("t1_rst_halted", halted, 1'b0);
    release_run();
    chk("t1_rom_addr", rom_addr, 8'h00);
    repeat (2) begin
      @(posedge CLK);
      #1;
      chk("t1_no_early_retire", retire, 1'b0);
    end
    @(posedge CLK);
    #1;
    chk("t1_retire_4th_cycle", retire, 1'b1);
    chk("t1_exec_we", ram_we, 1'b1);
    RST_N = 1'b0;
    #1;
    chk("t1_abort_we", ram_we, 1'b0);
    chk("t1_abort_retire", retire, 1'b0);
    chk("t1_abort_pc", pc, 8'h00);
    repeat (2) @(posedge CLK);
    #1;
    chk("t1_mem_unchanged", mem[8'h11], 8'd7);

    // 2) 7-3=4, no branch
    setup();
    rom[0] = {8'h10, 8'h11, 8'h05};
    rom[1] = {8'h10, 8'h12, 8'h00};
    setm(8'h10, 8'd3);
    setm(8'h11, 8'd7);
    setm(8'h12, 8'd2);
    release_run();
    wait_ret(1, 20);
    run = 1'b0;
    chk("t2_mem11", mem[8'h11], 8'd4);
    chk("t2_pc", pc, 8'h01);
    rc = retire_cnt;

    // 6) run=0 held in S_FETCH, then resume at PC=1: 2-3=FF, branch to 0
    repeat (10) @(posedge CLK);
    #1;
    chk("t2_single_retire", retire_cnt, rc);
    chk("t6_pc_held", pc, 8'h01);
    chk("t6_mem12_held", mem[8'h12], 8'd2);
    run = 1'b1;
    wait_ret(1, 20);
    run = 1'b0;
    chk("t6_mem12", mem[8'h12], 8'hFF);
    chk("t6_pc", pc, 8'h00);

    // 3) 7-7=0, branch on zero
    setup();
    rom[0] = {8'h10, 8'h11, 8'h05};
    setm(8'h10, 8'd7);
    setm(8'h11, 8'd7);
    release_run();
    wait_ret(1, 20);
    run = 1'b0;
    chk("t3_mem11", mem[8'h11], 8'h00);
    chk("t3_pc", pc, 8'h05);

    // 4a) 0x80-1 = 0x7F, positive, no branch
    setup();
    rom[0] = {8'h10, 8'h11, 8'h05};
    setm(8'h10, 8'h01);
    setm(8'h11, 8'h80);
    release_run();
    wait_ret(1, 20);
    run = 1'b0;
    chk("t4a_mem11", mem[8'h11], 8'h7F);
    chk("t4a_pc", pc, 8'h01);

    // 4b) 0-1 = 0xFF, negative, branch
    setup();
    rom[0] = {8'h10, 8'h11, 8'h05};
    setm(8'h10, 8'h01);
    setm(8'h11, 8'h00);
    release_run();
    wait_ret(1, 20);
    run = 1'b0;
    chk("t4b_mem11", mem[8'h11], 8'hFF);
    chk("t4b_pc", pc, 8'h05);

    // 5) non-taken branch to FF does not halt; A==B branch to FF halts
    setup();
    rom[0] = {8'h30, 8'h31, 8'h05};
    rom[1] = {8'h30, 8'h32, 8'hFF};
    rom[2] = {8'h20, 8'h20, 8'hFF};
    setm(8'h30, 8'd1);
    setm(8'h31, 8'd5);
    setm(8'h32, 8'd10);
    setm(8'h20, 8'd9);
    release_run();
    wait_ret(3, 40);
    chk("t5_mem31", mem[8'h31], 8'd4);
    chk("t5_mem32", mem[8'h32], 8'd9);
    chk("t5_mem20", mem[8'h20], 8'h00);
    chk("t5_halted", halted, 1'b1);
    chk("t5_pc", pc, 8'h02);
    rc = retire_cnt;
    repeat (10) begin
      @(posedge CLK);
      #1;
      chk("t5_halt_we", ram_we, 1'b0);
    end
    chk("t5_halt_pc", pc, 8'h02);
    chk("t5_no_more_retire", retire_cnt, rc);
    run = 1'b0;

    // 5b) PC walks 00 -> FE -> FF -> 00 (wrap on no branch)
    setup();
    rom[0]     = {8'h30, 8'h31, 8'hFE};
    rom[8'hFE] = {8'h40, 8'h41, 8'h00};
    rom[8'hFF] = {8'h40, 8'h41, 8'h00};
    setm(8'h30, 8'd5);
    setm(8'h31, 8'd5);
    setm(8'h40, 8'd1);
    setm(8'h41, 8'd10);
    release_run();
    wait_ret(3, 40);
    run = 1'b0;
    chk("t5b_pc_wrap", pc, 8'h00);
    chk("t5b_mem41", mem[8'h41], 8'd8);
    chk("t5b_halted", halted, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
